dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default `MEM_ADDR_WIDTH, the byte-address width on both ports and the memory side.
REQ-002 SHALL have parameter DATA_W, default `MEM_DATA_WIDTH (32), the data width.
REQ-003 SHALL have parameter STRB_W, default 4, the byte-strobe width (DATA_W/8).
REQ-004 One clock, clk; reset is synchronous and active-high, named rst.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 pN_req  in  1  port N (N=0,1) access request, held high until pN_ack.
REQ-008 pN_we  in  1  port N write (1) or read (0).
REQ-009 pN_addr  in  ADDR_W  port N byte address.
REQ-010 pN_wdata  in  DATA_W  port N write data.
REQ-011 pN_wstrb  in  STRB_W  port N byte enables; all-zero means full-word write.
REQ-012 pN_ack  out  1  one-cycle completion pulse for port N.
REQ-013 pN_rdata  out  DATA_W  port N registered read data, valid while pN_ack is high.
REQ-014 mem_we  out  1  data-memory write enable.
REQ-015 mem_addr  out  ADDR_W  data-memory address.
REQ-016 mem_data_in  out  DATA_W  data-memory write data.
REQ-017 mem_write_transfer  out  STRB_W  data-memory byte enables.
REQ-018 mem_data_out  in  DATA_W  data-memory combinational read data.

Function
REQ-019 FSM states: IDLE, ACCESS, DONE; IDLE->ACCESS when any pN_req=1; ACCESS->DONE unconditionally; DONE->IDLE unconditionally.
REQ-020 In IDLE with requests pending, winner SHALL be latched into register sel; lone requester wins; on tie, winner = port != last_gnt.
REQ-021 last_gnt SHALL update to sel on IDLE->ACCESS.
REQ-022 In ACCESS only: mem_addr/mem_data_in/mem_write_transfer = selected port's inputs, mem_we = selected pN_we.
REQ-023 Outside ACCESS: mem_we=0, mem_addr=0, mem_data_in=0, mem_write_transfer=0.
REQ-024 At end of ACCESS, mem_data_out SHALL be captured into the selected port's pN_rdata; the other port's rdata holds.
REQ-025 pN_ack SHALL be 1 exactly in DONE for port sel, 0 otherwise; both acks never high together.
REQ-026 Latency: req sampled in cycle T (IDLE) -> memory access in T+1 -> ack in T+2; throughput one access per 3 cycles.
REQ-027 Requests in DONE SHALL be ignored; arbitration restarts in the following IDLE cycle.
REQ-028 Requester inputs changing or req dropping during ACCESS: access uses the values present in ACCESS; ack still issued.
REQ-029 Address range is not checked; out-of-range accesses still complete and ack, with read data as returned by memory.
REQ-030 For a write, pN_rdata SHALL still capture mem_data_out (0 from memory while we=1).

Reset
REQ-031 On rst=1 at a clk edge: state=IDLE, sel=0, last_gnt=1, p0_ack=p1_ack=0, p0_rdata=p1_rdata=0.
REQ-032 Reset during ACCESS or DONE SHALL abort: no ack is issued, and mem_we=0 from the next cycle.
REQ-033 First arbitration after reset with both requesting SHALL grant port 0.

Structure
REQ-034 FSM state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and port count SHALL live in the shared defines include.
REQ-035 Sub-module dmem_rr_pick SHALL be combinational: inputs req[1:0] and last_gnt; outputs valid and winner.
REQ-036 The block SHALL connect directly to dataMem's we/addr/data_in/write_transfer_i/data_out pins without glue logic.

Verification
REQ-037 p0 write addr=0x10, wdata=0xDEADBEEF, wstrb=0 -> mem_we=1 for exactly one cycle; p0_ack 2 cycles after req; later p1 read 0x10 -> p1_rdata=0xDEADBEEF with p1_ack.
REQ-038 Both requests from reset, held continuously -> ack order p0,p1,p0,p1, with an ack every 3 cycles.
REQ-039 p1 write 0x20, wdata=0x11223344, wstrb=4'b0010 over prior 0 -> read of 0x20 returns 0x00003300.
REQ-040 rst asserted in the ACCESS cycle of a p0 write -> no p0_ack; state IDLE; memory word unchanged if rst and clk coincide before the write edge.
REQ-041 p0 drops req in ACCESS -> p0_ack still pulses once; no second access occurs.
REQ-042 Idle bus (no req) for 10 cycles -> mem_we, mem_addr and both acks stay 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// dmem_arbiter_pkg : shared defines, state encodings and port count
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef DMEM_ARBITER_DEFINES
`define DMEM_ARBITER_DEFINES
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 32
`endif
`define DMEM_NUM_PORTS 2
`define DMEM_ST_IDLE   2'd0
`define DMEM_ST_ACCESS 2'd1
`define DMEM_ST_DONE   2'd2
`endif

package dmem_arbiter_pkg;

   localparam int NUM_PORTS = `DMEM_NUM_PORTS;

   typedef enum logic [1:0] {
      ST_IDLE   = `DMEM_ST_IDLE,
      ST_ACCESS = `DMEM_ST_ACCESS,
      ST_DONE   = `DMEM_ST_DONE
   } dmem_state_e;

endpackage

`default_nettype wire

// File: rtl/dmem_rr_pick.sv
// ============================================================================
// dmem_rr_pick : two-port round-robin winner selection (combinational)
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_rr_pick
   import dmem_arbiter_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req,
   input  logic                 last_gnt,
   output logic                 valid,
   output logic                 winner
);

   always_comb begin
      valid  = |req;
      winner = 1'b0;
      case (req)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         // On a tie the port that was not granted last time goes next.
         2'b11:   winner = ~last_gnt;
         default: winner = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : two-port round-robin arbiter in front of a single data memory
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = `MEM_ADDR_WIDTH,
   parameter int DATA_W = `MEM_DATA_WIDTH,
   parameter int STRB_W = 4
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   input  logic [STRB_W-1:0] p0_wstrb,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,

   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   input  logic [STRB_W-1:0] p1_wstrb,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,

   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   output logic [STRB_W-1:0] mem_write_transfer,
   input  logic [DATA_W-1:0] mem_data_out
);

   dmem_state_e       state_q, state_d;
   logic              sel_q, sel_d;
   logic              last_gnt_q, last_gnt_d;
   logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
   logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

   logic              pick_valid;
   logic              pick_winner;

   dmem_rr_pick u_pick (
      .req      ({p1_req, p0_req}),
      .last_gnt (last_gnt_q),
      .valid    (pick_valid),
      .winner   (pick_winner)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sel_q      <= 1'b0;
         last_gnt_q <= 1'b1;
         p0_rdata_q <= '0;
         p1_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         last_gnt_q <= last_gnt_d;
         p0_rdata_q <= p0_rdata_d;
         p1_rdata_q <= p1_rdata_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      sel_d              = sel_q;
      last_gnt_d         = last_gnt_q;
      p0_rdata_d         = p0_rdata_q;
      p1_rdata_d         = p1_rdata_q;
      mem_we             = 1'b0;
      mem_addr           = '0;
      mem_data_in        = '0;
      mem_write_transfer = '0;

      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               sel_d      = pick_winner;
               last_gnt_d = pick_winner;
               state_d    = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // Requester inputs are taken live here, so late changes win.
            if (sel_q) begin
               mem_we             = p1_we;
               mem_addr           = p1_addr;
               mem_data_in        = p1_wdata;
               mem_write_transfer = p1_wstrb;
               p1_rdata_d         = mem_data_out;
            end else begin
               mem_we             = p0_we;
               mem_addr           = p0_addr;
               mem_data_in        = p0_wdata;
               mem_write_transfer = p0_wstrb;
               p0_rdata_d         = mem_data_out;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign p0_ack   = (state_q == ST_DONE) && !sel_q;
   assign p1_ack   = (state_q == ST_DONE) &&  sel_q;
   assign p0_rdata = p0_rdata_q;
   assign p1_rdata = p1_rdata_q;

endmodule

`default_nettype wire
